// File: rtl/tinker_mem_responder.sv
// tinker_mem_responder: one-at-a-time, fixed-latency big-endian memory slave for fetch/load/store traffic.
module tinker_mem_responder #(
  parameter int MEM_SIZE = 524288,
  parameter int LATENCY  = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [1:0]  req_op,
  input  logic [31:0] req_addr,
  input  logic [63:0] req_wdata,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [63:0] rsp_rdata,
  output logic        rsp_err
);
  localparam int AW = $clog2(MEM_SIZE);
  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;
  state_t state;
  logic [3:0] cnt;
  logic [1:0] op_q;
  logic [31:0] addr_q;
  logic [63:0] wdata_q;
  logic [7:0] bytes [0:MEM_SIZE-1];
  logic [1:0] c_op;
  logic [31:0] c_addr;
  logic [63:0] c_wdata;
  logic [AW-1:0] c_idx;
  logic hs, commit, err;
  logic [63:0] rd8, rdata_n;
  // With LATENCY 1 the commit edge is the handshake edge, so the live request is used directly.
  always_comb begin
    hs = req_valid && req_ready;
    c_op = state == IDLE ? req_op : op_q;
    c_addr = state == IDLE ? req_addr : addr_q;
    c_wdata = state == IDLE ? req_wdata : wdata_q;
    c_idx = c_addr[AW-1:0];
    commit = state == WAIT ? cnt == 4'd0 : state == IDLE && hs && LATENCY == 1;
    err = c_op == 2'b11 || ({1'b0, c_addr} + (c_op == 2'b00 ? 33'd4 : 33'd8)) > 33'(MEM_SIZE);
    rd8 = '0;
    for (int i = 0; i < 8; i++) rd8[63-8*i -: 8] = bytes[c_idx + AW'(i)];
    rdata_n = err || c_op == 2'b10 ? '0 : c_op == 2'b00 ? {32'b0, rd8[63:32]} : rd8;
  end
  always_ff @(posedge clk)
    if (commit && c_op == 2'b10 && !err)
      for (int i = 0; i < 8; i++) bytes[c_idx + AW'(i)] <= c_wdata[63-8*i -: 8];
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
      cnt <= '0;
      req_ready <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
      rsp_err <= 1'b0;
      op_q <= '0;
      addr_q <= '0;
      wdata_q <= '0;
    end else begin
      case (state)
        IDLE: begin
          req_ready <= !hs;
          if (hs) begin
            op_q <= req_op;
            addr_q <= req_addr;
            wdata_q <= req_wdata;
            state <= LATENCY == 1 ? RESP : WAIT;
            cnt <= 4'(LATENCY - 2);
          end
        end
        WAIT: if (cnt != 4'd0) cnt <= cnt - 4'd1; else state <= RESP;
        default: if (rsp_ready) begin
          state <= IDLE;
          rsp_valid <= 1'b0;
          req_ready <= 1'b1;
        end
      endcase
      if (commit) begin
        rsp_valid <= 1'b1;
        rsp_rdata <= rdata_n;
        rsp_err <= err;
      end
    end
  end
endmodule

// File: tb/tb_tinker_mem_responder.sv
// tb_tinker_mem_responder: directed vectors for the fixed-latency memory responder.
module tb_tinker_mem_responder;
  localparam int MS = 524288;
  logic clk = 0, reset = 0, reset_4 = 0, req_valid = 0, req_valid_4 = 0, rsp_ready = 0;
  logic [1:0] req_op = 0;
  logic [31:0] req_addr = 0;
  logic [63:0] req_wdata = 0;
  logic req_ready, rsp_valid, rsp_err, req_ready_4, rsp_valid_4, rsp_err_4;
  logic [63:0] rsp_rdata, rsp_rdata_4;
  int total = 0, bad = 0;
  always #5 clk = ~clk;
  tinker_mem_responder #(.MEM_SIZE(MS), .LATENCY(2)) u0 (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
    .req_addr(req_addr), .req_wdata(req_wdata), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_rdata(rsp_rdata), .rsp_err(rsp_err));
  tinker_mem_responder #(.MEM_SIZE(65536), .LATENCY(4)) u1 (
    .clk(clk), .reset(reset_4), .req_valid(req_valid_4), .req_ready(req_ready_4), .req_op(req_op),
    .req_addr(req_addr), .req_wdata(req_wdata), .rsp_valid(rsp_valid_4), .rsp_ready(rsp_ready),
    .rsp_rdata(rsp_rdata_4), .rsp_err(rsp_err_4));
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask
  task automatic send(input logic [1:0] op, input logic [31:0] a, input logic [63:0] d);
    int n = 0;
    @(negedge clk);
    while (!req_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("req_wait", 64'(n < 20), 1);
    req_valid = 1; req_op = op; req_addr = a; req_wdata = d;
    @(negedge clk);
    req_valid = 0;
    chk("busy", req_ready, 0);
  endtask
  task automatic wait_rsp(output int lat);
    lat = 1;
    while (!rsp_valid && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    chk("rsp_wait", rsp_valid, 1);
  endtask
  task automatic done_rsp();
    rsp_ready = 1;
    @(negedge clk);
    rsp_ready = 0;
    chk("ready_back", req_ready, 1);
    chk("rsp_drop", rsp_valid, 0);
  endtask
  task automatic xact(input string tag, input logic [1:0] op, input logic [31:0] a,
                      input logic [63:0] d, input logic [63:0] exp_rd, input logic exp_err);
    int lat;
    send(op, a, d);
    wait_rsp(lat);
    chk({tag, "_lat"}, lat, 2);
    chk({tag, "_rd"}, rsp_rdata, exp_rd);
    chk({tag, "_err"}, rsp_err, exp_err);
    chk({tag, "_busy"}, req_ready, 0);
    done_rsp();
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end
  initial begin
    int lat;
    u0.bytes[32'h2000] = 8'hC8; u0.bytes[32'h2001] = 8'h00;
    u0.bytes[32'h2002] = 8'h00; u0.bytes[32'h2003] = 8'h05;
    for (int i = 0; i < 8; i++) u0.bytes[MS-8+i] = 8'(i + 1);
    for (int i = 0; i < 8; i++) u1.bytes[32'h3000+i] = 8'hAA;
    req_valid = 1;
    repeat (3) @(negedge clk);
    chk("rst_ready", req_ready, 0);
    chk("rst_valid", rsp_valid, 0);
    chk("rst_rdata", rsp_rdata, 0);
    chk("rst_err", rsp_err, 0);
    reset = 1; reset_4 = 1; req_valid = 0;
    @(negedge clk);
    chk("rel_ready", req_ready, 1);
    chk("rel_ready4", req_ready_4, 1);
    xact("fetch", 2'b00, 32'h2000, 0, 64'h00000000_C8000005, 0);
    xact("store", 2'b10, 32'hFFF8, 64'h1122334455667788, 0, 0);
    chk("st_b0", u0.bytes[32'hFFF8], 8'h11);
    chk("st_b7", u0.bytes[32'hFFFF], 8'h88);
    xact("load", 2'b01, 32'hFFF8, 0, 64'h1122334455667788, 0);
    send(2'b01, 32'hFFF8, 0);
    wait_rsp(lat);
    repeat (5) begin
      @(negedge clk);
      chk("bp_valid", rsp_valid, 1);
      chk("bp_data", rsp_rdata, 64'h1122334455667788);
    end
    done_rsp();
    xact("ld_top", 2'b01, MS - 8, 0, 64'h0102030405060708, 0);
    xact("ld_over", 2'b01, MS - 7, 0, 0, 1);
    xact("fe_top", 2'b00, MS - 4, 0, 64'h00000000_05060708, 0);
    xact("st_wrap", 2'b10, 32'hFFFFFFFC, 64'hFFFFFFFF_FFFFFFFF, 0, 1);
    for (int i = 0; i < 4; i++) chk("st_wrap_mem", u0.bytes[MS-4+i], 64'(5 + i));
    xact("rsvd", 2'b11, 32'h2000, 0, 0, 1);
    req_op = 2'b00; req_addr = 32'h3000; req_valid_4 = 1;
    @(negedge clk);
    req_valid_4 = 0;
    lat = 1;
    while (!rsp_valid_4 && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    chk("l4_lat", lat, 4);
    chk("l4_rd", rsp_rdata_4, 64'h00000000_AAAAAAAA);
    rsp_ready = 1;
    @(negedge clk);
    rsp_ready = 0;
    chk("l4_ready", req_ready_4, 1);
    req_op = 2'b10; req_addr = 32'h3000; req_wdata = 64'hDEAD; req_valid_4 = 1;
    @(negedge clk);
    req_valid_4 = 0;
    @(negedge clk);
    reset_4 = 0;
    repeat (3) begin
      @(negedge clk);
      chk("mid_rst_valid", rsp_valid_4, 0);
    end
    reset_4 = 1;
    repeat (4) begin
      @(negedge clk);
      chk("post_rst_valid", rsp_valid_4, 0);
    end
    chk("post_rst_ready", req_ready_4, 1);
    for (int i = 0; i < 8; i++) chk("mid_rst_mem", u1.bytes[32'h3000+i], 8'hAA);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
